data_mem_lsu: RTL and testbench

Parametrised, clocked successor to the core's data memory. Single-port, byte-addressed, little-endian word store with RISC-V sub-word access: SB/SH/SW via byte enables; LB/LH/LW/LBU/LHU with sign/zero extension. Adds registered reads, alignment and range checking, and a hardware clear sweep after reset. Sits in the MEM stage between the ALU address output and the writeback mux.

---
 rtl/data_mem_pkg.sv | 27 ++
 rtl/data_mem_load_align.sv | 27 ++
 rtl/data_mem_lsu.sv | 161 ++++++++++++++++
 tb/tb_data_mem_lsu.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_pkg.sv
// Shared constants and types for the data memory load/store unit.
// Holds RISC-V funct3 encodings, the FSM state enum, and funct3 legality helpers.
package data_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int BE_W = 4;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } state_e;

  function automatic logic is_load_f3(input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  function automatic logic is_store_f3(input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
  endfunction

endpackage

// File: rtl/data_mem_load_align.sv
// Combinational load formatter: selects the addressed byte/halfword from a
// raw little-endian word and applies sign or zero extension.
module data_mem_load_align
  import data_mem_pkg::*;
(
  input  logic [31:0] raw_word,
  input  logic [1:0]  lane,
  input  logic [2:0]  funct3,
  output logic [31:0] load_data
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  always_comb begin
    lane_byte = raw_word[{lane, 3'b000} +: 8];
    lane_half = lane[1] ? raw_word[31:16] : raw_word[15:0];
    case (funct3)
      F3_B:    load_data = {{24{lane_byte[7]}}, lane_byte};
      F3_BU:   load_data = {24'h0, lane_byte};
      F3_H:    load_data = {{16{lane_half[15]}}, lane_half};
      F3_HU:   load_data = {16'h0, lane_half};
      default: load_data = raw_word;
    endcase
  end

endmodule

// File: rtl/data_mem_lsu.sv
// MEM-stage data memory: byte-enabled word array with registered loads,
// alignment/range/funct3 checking and a post-reset clear sweep.
module data_mem_lsu
  import data_mem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 256,
  parameter int          ADDR_WIDTH  = 32,
  parameter logic [31:0] INIT_WORD   = 32'h0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  memRead,
  input  logic                  memWrite,
  input  logic [2:0]            funct3,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [31:0]           memWriteData,
  output logic [31:0]           readData,
  output logic                  readValid,
  output logic                  memReady,
  output logic                  misaligned,
  output logic                  accessFault,
  output state_e                dbg_state
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH_WORDS - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic [31:0]      mem_q [DEPTH_WORDS];

  logic [31:0] read_data_q, read_data_d;
  logic        read_valid_q, read_valid_d;
  logic        misaligned_q, misaligned_d;
  logic        access_fault_q, access_fault_d;

  logic [ADDR_WIDTH-3:0] word_idx;
  logic [IDX_W-1:0]      mem_idx;
  logic [1:0]            lane;
  logic                  req, f3_ok, mis, oor, access_ok;
  logic [31:0]           raw_word, load_data;

  logic                  wr_en;
  logic [IDX_W-1:0]      wr_idx;
  logic [BE_W-1:0]       wr_be;
  logic [31:0]           wr_data;

  // Handshake: memRead/memWrite act as valid, memReady as ready. A request
  // transfers on a rising edge where valid and memReady are both high; there
  // is no backpressure once READY, and requests seen while not ready are dropped.
  assign memReady = (state_q == READY);

  always_comb begin
    word_idx  = address[ADDR_WIDTH-1:2];
    mem_idx   = word_idx[IDX_W-1:0];
    lane      = address[1:0];
    req       = memReady && (memRead || memWrite);
    f3_ok     = memWrite ? is_store_f3(funct3) : is_load_f3(funct3);
    mis       = ((funct3[1:0] == 2'b01) && address[0]) ||
                ((funct3[1:0] == 2'b10) && (address[1:0] != 2'b00));
    oor       = 64'(word_idx) >= 64'(DEPTH_WORDS);
    access_ok = req && f3_ok && !mis && !oor;
    raw_word  = mem_q[mem_idx];
  end

  data_mem_load_align u_load_align (
    .raw_word  (raw_word),
    .lane      (lane),
    .funct3    (funct3),
    .load_data (load_data)
  );

  // Single write port shared by the clear sweep and accepted stores.
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = mem_idx;
    wr_be   = '0;
    wr_data = memWriteData;
    if (!reset) begin
      if (state_q == INIT) begin
        wr_en   = 1'b1;
        wr_idx  = cnt_q;
        wr_be   = 4'b1111;
        wr_data = INIT_WORD;
      end else if (access_ok && memWrite) begin
        wr_en = 1'b1;
        case (funct3[1:0])
          2'b00: begin
            wr_be   = 4'b0001 << lane;
            wr_data = {4{memWriteData[7:0]}};
          end
          2'b01: begin
            wr_be   = lane[1] ? 4'b1100 : 4'b0011;
            wr_data = {2{memWriteData[15:0]}};
          end
          default: wr_be = 4'b1111;
        endcase
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    read_data_d    = read_data_q;
    read_valid_d   = 1'b0;
    misaligned_d   = 1'b0;
    access_fault_d = 1'b0;
    case (state_q)
      INIT: begin
        cnt_d = cnt_q + IDX_W'(1);
        if (cnt_q == LAST_IDX) state_d = READY;
      end
      READY: begin
        if (req) begin
          if (!f3_ok)      access_fault_d = 1'b1;
          else if (mis)    misaligned_d   = 1'b1;
          else if (oor)    access_fault_d = 1'b1;
          else if (memRead && !memWrite) begin
            read_data_d  = load_data;
            read_valid_d = 1'b1;
          end
        end
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= INIT;
      cnt_q          <= '0;
      read_data_q    <= '0;
      read_valid_q   <= 1'b0;
      misaligned_q   <= 1'b0;
      access_fault_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      read_data_q    <= read_data_d;
      read_valid_q   <= read_valid_d;
      misaligned_q   <= misaligned_d;
      access_fault_q <= access_fault_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < BE_W; i++) begin
        if (wr_be[i]) mem_q[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  assign readData    = read_data_q;
  assign readValid   = read_valid_q;
  assign misaligned  = misaligned_q;
  assign accessFault = access_fault_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_data_mem_lsu.sv
// Self-checking bench for data_mem_lsu: reset sweep, load extension, sub-word
// stores, fault priority, read/write conflict, back-to-back traffic, re-reset.
module tb_data_mem_lsu;
  import data_mem_pkg::*;

  localparam int          DEPTH  = 16;
  localparam logic [31:0] INIT_W = 32'hA5C3_5A3C;
  localparam logic [1:0]  K_NONE = 2'd0, K_LOAD = 2'd1, K_MIS = 2'd2, K_FAULT = 2'd3;

  logic        clk = 1'b0;
  logic        reset, memRead, memWrite;
  logic [2:0]  funct3;
  logic [31:0] address, memWriteData, readData;
  logic        readValid, memReady, misaligned, accessFault;
  state_e      dbg_state;

  int          total = 0;
  int          bad = 0;
  logic [33:0] exp_q[$];
  string       name_q[$];
  int          due_cnt = 0;
  bit          mon_en = 1'b0;
  logic [31:0] last_rd = 32'h0;
  logic [31:0] b2b_mem [8];

  logic [33:0] mon_e;
  string       mon_n;
  logic [1:0]  mon_k;

  data_mem_lsu #(.DEPTH_WORDS(DEPTH), .ADDR_WIDTH(32), .INIT_WORD(INIT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .memRead      (memRead),
    .memWrite     (memWrite),
    .funct3       (funct3),
    .address      (address),
    .memWriteData (memWriteData),
    .readData     (readData),
    .readValid    (readValid),
    .memReady     (memReady),
    .misaligned   (misaligned),
    .accessFault  (accessFault),
    .dbg_state    (dbg_state)
  );

  // clock/reset
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: sim time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // scoreboard: one expected response per accepted request, checked the
  // negedge after its sampling edge; cycles with nothing due must be quiet
  always @(negedge clk) begin
    if (mon_en) begin
      if (due_cnt > 0) begin
        due_cnt--;
        mon_e = exp_q.pop_front();
        mon_n = name_q.pop_front();
        mon_k = mon_e[33:32];
        total++;
        if (readValid !== (mon_k == K_LOAD) || misaligned !== (mon_k == K_MIS) ||
            accessFault !== (mon_k == K_FAULT) || readData !== mon_e[31:0]) begin
          bad++;
          $display("FAIL %s: got rv=%b mis=%b af=%b rd=%h, want rv=%b mis=%b af=%b rd=%h",
                   mon_n, readValid, misaligned, accessFault, readData,
                   (mon_k == K_LOAD), (mon_k == K_MIS), (mon_k == K_FAULT), mon_e[31:0]);
        end
      end else begin
        total++;
        if (readValid !== 1'b0 || misaligned !== 1'b0 || accessFault !== 1'b0) begin
          bad++;
          $display("FAIL idle_quiet: got rv=%b mis=%b af=%b, want all 0",
                   readValid, misaligned, accessFault);
        end
      end
    end
  end

  // driver tasks
  task automatic req(input logic rd, input logic wr, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] wd,
                     input logic [1:0] kind, input logic [31:0] exp_rd, input string nm);
    @(negedge clk);
    memRead      = rd;
    memWrite     = wr;
    funct3       = f3;
    address      = addr;
    memWriteData = wd;
    if (kind == K_LOAD) last_rd = exp_rd;
    exp_q.push_back({kind, last_rd});
    name_q.push_back(nm);
    @(posedge clk);
    #1;
    memRead  = 1'b0;
    memWrite = 1'b0;
    due_cnt++;
  endtask

  task automatic ld(input logic [2:0] f3, input logic [31:0] addr,
                    input logic [31:0] exp_rd, input string nm);
    req(1'b1, 1'b0, f3, addr, 32'h0, K_LOAD, exp_rd, nm);
  endtask

  task automatic st(input logic [2:0] f3, input logic [31:0] addr,
                    input logic [31:0] wd, input string nm);
    req(1'b0, 1'b1, f3, addr, wd, K_NONE, 32'h0, nm);
  endtask

  task automatic test_reset;
    reset = 1'b1; memRead = 1'b0; memWrite = 1'b0;
    funct3 = 3'b000; address = 32'h0; memWriteData = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (readData !== 32'h0) begin bad++; $display("FAIL rst_readData: got %h want 0", readData); end
    total++; if (readValid !== 1'b0) begin bad++; $display("FAIL rst_readValid: got %b want 0", readValid); end
    total++; if (misaligned !== 1'b0) begin bad++; $display("FAIL rst_misaligned: got %b want 0", misaligned); end
    total++; if (accessFault !== 1'b0) begin bad++; $display("FAIL rst_accessFault: got %b want 0", accessFault); end
    total++; if (memReady !== 1'b0) begin bad++; $display("FAIL rst_memReady: got %b want 0", memReady); end
    reset  = 1'b0;
    mon_en = 1'b1;
    for (int k = 1; k <= DEPTH; k++) begin
      @(negedge clk);
      total++;
      if (memReady !== (k == DEPTH)) begin
        bad++;
        $display("FAIL sweep_ready k=%0d: got %b want %b", k, memReady, (k == DEPTH));
      end
      if (k == 4) begin
        memWrite = 1'b1; funct3 = F3_W; address = 32'h0; memWriteData = 32'hDEAD_BEEF;
      end else if (k == 6) begin
        memWrite = 1'b0; memRead = 1'b1;
      end else if (k == 8) begin
        memRead = 1'b0;
      end
    end
    ld(F3_W, 32'h0, INIT_W, "init_lw0");
  endtask

  task automatic test_load_ext;
    st(F3_W,  32'h8, 32'h80FF_7F01, "ext_sw8");
    ld(F3_B,  32'h8, 32'h0000_0001, "ext_lb8");
    ld(F3_B,  32'h9, 32'h0000_007F, "ext_lb9");
    ld(F3_B,  32'hA, 32'hFFFF_FFFF, "ext_lbA");
    ld(F3_BU, 32'hA, 32'h0000_00FF, "ext_lbuA");
    ld(F3_B,  32'hB, 32'hFFFF_FF80, "ext_lbB");
    ld(F3_BU, 32'hB, 32'h0000_0080, "ext_lbuB");
    ld(F3_H,  32'hA, 32'hFFFF_80FF, "ext_lhA");
    ld(F3_HU, 32'hA, 32'h0000_80FF, "ext_lhuA");
    ld(F3_H,  32'h8, 32'h0000_7F01, "ext_lh8");
  endtask

  task automatic test_sub_word;
    st(F3_W, 32'h4, 32'h1122_3344, "sw4");
    st(F3_B, 32'h5, 32'h1234_56AB, "sb5");
    ld(F3_W, 32'h4, 32'h1122_AB44, "lw4_after_sb");
    st(F3_H, 32'h6, 32'h5555_BEEF, "sh6");
    ld(F3_W, 32'h4, 32'hBEEF_AB44, "lw4_after_sh");
  endtask

  task automatic test_faults;
    req(1'b1, 1'b0, F3_W, 32'h6,  32'h0, K_MIS, 32'h0, "mis_lw6");
    req(1'b0, 1'b1, F3_H, 32'h3,  32'hFFFF_FFFF, K_MIS, 32'h0, "mis_sh3");
    ld(F3_W, 32'h0, INIT_W, "after_mis_lw0");
    ld(F3_W, 32'h4, 32'hBEEF_AB44, "after_mis_lw4");
    ld(F3_W, 32'h3C, INIT_W, "last_word_lw");
    req(1'b1, 1'b0, F3_W, DEPTH * 4, 32'h0, K_FAULT, 32'h0, "oor_lw");
    req(1'b1, 1'b0, 3'b011, 32'h0, 32'h0, K_FAULT, 32'h0, "f3_011_load");
    req(1'b1, 1'b0, 3'b110, 32'h0, 32'h0, K_FAULT, 32'h0, "f3_110_load");
    req(1'b0, 1'b1, F3_BU, 32'h0, 32'h1234_5678, K_FAULT, 32'h0, "f3_100_store");
    req(1'b1, 1'b0, 3'b011, 32'h41, 32'h0, K_FAULT, 32'h0, "prio_f3_over_mis");
    req(1'b1, 1'b0, F3_H, 32'h41, 32'h0, K_MIS, 32'h0, "prio_mis_over_oor");
    ld(F3_W, 32'h0, INIT_W, "after_fault_lw0");
  endtask

  task automatic test_conflict;
    req(1'b1, 1'b1, F3_W, 32'h0, 32'hCAFE_F00D, K_NONE, 32'h0, "rw_conflict");
    ld(F3_W, 32'h0, 32'hCAFE_F00D, "conflict_lw0");
  endtask

  task automatic test_back_to_back;
    logic [1:0] ln;
    for (int i = 0; i < 8; i++) begin
      b2b_mem[i] = $urandom;
      st(F3_W, 32'h20 + 32'(4 * i), b2b_mem[i], "b2b_sw");
    end
    for (int i = 0; i < 8; i++) begin
      ld(F3_W, 32'h20 + 32'(4 * i), b2b_mem[i], "b2b_lw");
      ln = 2'($urandom_range(0, 3));
      ld(F3_BU, 32'h20 + 32'(4 * i) + 32'(ln), (b2b_mem[i] >> (8 * ln)) & 32'hFF, "b2b_lbu");
    end
  endtask

  task automatic test_reset_rerun;
    ld(F3_W, 32'h0, 32'hCAFE_F00D, "pre_reset_lw0");
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset   = 1'b0;
    last_rd = 32'h0;
    @(negedge clk);
    total++; if (readData !== 32'h0) begin bad++; $display("FAIL rerst_readData: got %h want 0", readData); end
    total++; if (memReady !== 1'b0) begin bad++; $display("FAIL rerst_memReady: got %b want 0", memReady); end
    for (int k = 1; k <= DEPTH; k++) begin
      @(negedge clk);
      total++;
      if (memReady !== (k == DEPTH)) begin
        bad++;
        $display("FAIL resweep_ready k=%0d: got %b want %b", k, memReady, (k == DEPTH));
      end
    end
    ld(F3_W, 32'h0, INIT_W, "resweep_lw0");
    ld(F3_W, 32'h20, INIT_W, "resweep_lw20");
  endtask

  initial begin
    test_reset();
    test_load_ext();
    test_sub_word();
    test_faults();
    test_conflict();
    test_back_to_back();
    test_reset_rerun();
    @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL leftover_expected: got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
